// File: rtl/video_rect_fill_pkg.sv
// Shared constants, register map and FSM encoding for the rectangle-fill engine.
// Also holds the helper that turns a row and column into a framebuffer word address.
package video_rect_fill_pkg;

  localparam logic [31:0] REG_BASE     = 32'hFF20_0000;
  localparam logic [31:0] FB_BASE      = 32'hFF00_0000;
  localparam logic [31:0] FRAME_STRIDE = 32'h0010_0000;
  localparam logic [9:0]  SCREEN_W     = 10'd320;
  localparam logic [8:0]  SCREEN_H     = 9'd240;

  localparam logic [1:0] OFF_CTRL  = 2'd0;
  localparam logic [1:0] OFF_POS   = 2'd1;
  localparam logic [1:0] OFF_SIZE  = 2'd2;
  localparam logic [1:0] OFF_COLOR = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_FRAME = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_BUSY  = 8;
  localparam int CTRL_DONE  = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_ROW   = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } fill_state_e;

  // row*320 is built as row*256 + row*64 to keep it a pair of shifts.
  function automatic logic [31:0] word_addr(input logic frame, input logic [8:0] row,
                                            input logic [9:0] col);
    logic [31:0] row_w;
    row_w = {23'd0, row};
    return FB_BASE + (frame ? FRAME_STRIDE : 32'd0) + (row_w << 8) + (row_w << 6)
           + {22'd0, col[9:2], 2'b00};
  endfunction

endpackage

// File: rtl/video_rect_fill_if.sv
// Register-slave and fill-master signals of the rectangle-fill engine.
// The slave modport is the engine's view; master is the system/bench view.
interface video_rect_fill_if;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [31:0] bus_data_fetched;

  logic [31:0] fill_address;
  logic [31:0] fill_write_data;
  logic [3:0]  fill_byte_enable;
  logic        fill_write_request;
  logic        fill_ready;
  logic        fill_busy;
  logic        fill_done;

  modport slave (
    input  bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
    input  fill_ready,
    output bus_data_fetched,
    output fill_address, fill_write_data, fill_byte_enable, fill_write_request,
    output fill_busy, fill_done
  );

  modport master (
    output bus_address, bus_write_data, bus_byte_enable, bus_read_enable, bus_write_enable,
    output fill_ready,
    input  bus_data_fetched,
    input  fill_address, fill_write_data, fill_byte_enable, fill_write_request,
    input  fill_busy, fill_done
  );
endinterface

// File: rtl/video_rect_fill_lane_mask.sv
// Byte-lane enables for one framebuffer word: lanes from the first column up to
// the last column when both fall in the same word, otherwise up to lane 3.
module rect_fill_lane_mask (
  input  logic [1:0] first_i,
  input  logic [1:0] last_i,
  input  logic       same_word_i,
  output logic [3:0] enable_o
);
  always_comb begin
    enable_o = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      if ((2'(n) >= first_i) && (!same_word_i || (2'(n) <= last_i))) begin
        enable_o[n] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/video_rect_fill.sv
// Rectangle-fill engine: memory-mapped config registers plus a bus master that
// writes the clipped rectangle one 32-bit word per accepted cycle.
module video_rect_fill
  import video_rect_fill_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  video_rect_fill_if.slave  bus
);

  fill_state_e state_q;
  logic        frame_q, done_q, req_q, done_pulse_q;
  logic [8:0]  pos_x_q, size_w_q;
  logic [7:0]  pos_y_q, size_h_q, color_q;
  logic [9:0]  col_q, x0_q, x1_q;
  logic [8:0]  row_q, y1_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;

  logic        in_win, wr, ctrl_wr, busy, start_cmd, abort_cmd, accept;
  logic [1:0]  off;
  logic [31:0] wd;
  logic [9:0]  x_end, x1_calc, col_step, col_d, x1_sel, last_col;
  logic [8:0]  y_end, y1_calc, row_d;
  logic        empty, same_word, row_last_word, last_row;
  logic [3:0]  be_d;
  logic        unused_bits;

  assign in_win    = (bus.bus_address[31:4] == REG_BASE[31:4]);
  assign off       = bus.bus_address[3:2];
  assign wd        = bus.bus_write_data;
  assign wr        = bus.bus_write_enable && in_win;
  assign ctrl_wr   = wr && (off == OFF_CTRL) && bus.bus_byte_enable[0];
  assign busy      = (state_q != ST_IDLE);
  assign start_cmd = ctrl_wr && wd[CTRL_START] && !busy;
  assign abort_cmd = ctrl_wr && wd[CTRL_ABORT] && busy;
  assign accept    = req_q && bus.fill_ready;
  assign unused_bits = ^{bus.bus_address[1:0], wd[31:24], wd[15:9]};

  // Clipping: 10-bit x and 9-bit y sums cannot wrap for any register value.
  assign x_end   = {1'b0, pos_x_q} + {1'b0, size_w_q};
  assign x1_calc = (x_end > SCREEN_W) ? SCREEN_W : x_end;
  assign y_end   = {1'b0, pos_y_q} + {1'b0, size_h_q};
  assign y1_calc = (y_end > SCREEN_H) ? SCREEN_H : y_end;
  assign empty   = (size_w_q == 9'd0) || (size_h_q == 8'd0) ||
                   ({1'b0, pos_x_q} >= SCREEN_W) || ({1'b0, pos_y_q} >= SCREEN_H);

  // Position of the word to present next, depending on how the FSM moves on.
  always_comb begin
    col_step = (col_q | 10'd3) + 10'd1;
    col_d    = col_step;
    row_d    = row_q;
    x1_sel   = x1_q;
    if (state_q == ST_SETUP) begin
      col_d  = {1'b0, pos_x_q};
      row_d  = {1'b0, pos_y_q};
      x1_sel = x1_calc;
    end else if (state_q == ST_NEXT) begin
      col_d  = x0_q;
      row_d  = row_q + 9'd1;
    end
    last_col  = x1_sel - 10'd1;
    same_word = (col_d[9:2] == last_col[9:2]);
  end

  assign row_last_word = (col_step >= x1_q);
  assign last_row      = ((row_q + 9'd1) >= y1_q);

  rect_fill_lane_mask u_lane_mask (
    .first_i     (col_d[1:0]),
    .last_i      (last_col[1:0]),
    .same_word_i (same_word),
    .enable_o    (be_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      frame_q      <= 1'b0;
      done_q       <= 1'b0;
      req_q        <= 1'b0;
      done_pulse_q <= 1'b0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      size_w_q     <= '0;
      size_h_q     <= '0;
      color_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      addr_q       <= '0;
      be_q         <= '0;
    end else begin
      done_pulse_q <= 1'b0;

      if (wr && !busy) begin
        case (off)
          OFF_CTRL: if (bus.bus_byte_enable[0]) frame_q <= wd[CTRL_FRAME];
          OFF_POS: begin
            if (bus.bus_byte_enable[0]) pos_x_q[7:0] <= wd[7:0];
            if (bus.bus_byte_enable[1]) pos_x_q[8]   <= wd[8];
            if (bus.bus_byte_enable[2]) pos_y_q      <= wd[23:16];
          end
          OFF_SIZE: begin
            if (bus.bus_byte_enable[0]) size_w_q[7:0] <= wd[7:0];
            if (bus.bus_byte_enable[1]) size_w_q[8]   <= wd[8];
            if (bus.bus_byte_enable[2]) size_h_q      <= wd[23:16];
          end
          default: if (bus.bus_byte_enable[0]) color_q <= wd[7:0];
        endcase
      end

      if (start_cmd) done_q <= 1'b0;

      case (state_q)
        ST_IDLE: if (start_cmd) state_q <= ST_SETUP;
        ST_SETUP: begin
          x0_q <= col_d;
          x1_q <= x1_calc;
          y1_q <= y1_calc;
          if (empty) begin
            state_q      <= ST_DONE;
            done_pulse_q <= 1'b1;
          end else begin
            state_q <= ST_ROW;
            col_q   <= col_d;
            row_q   <= row_d;
            req_q   <= 1'b1;
            addr_q  <= word_addr(frame_q, row_d, col_d);
            be_q    <= be_d;
          end
        end
        ST_ROW: if (accept) begin
          if (row_last_word) begin
            req_q <= 1'b0;
            if (last_row) begin
              state_q      <= ST_DONE;
              done_pulse_q <= 1'b1;
            end else begin
              state_q <= ST_NEXT;
            end
          end else begin
            col_q  <= col_d;
            addr_q <= word_addr(frame_q, row_d, col_d);
            be_q   <= be_d;
          end
        end
        ST_NEXT: begin
          state_q <= ST_ROW;
          col_q   <= col_d;
          row_q   <= row_d;
          req_q   <= 1'b1;
          addr_q  <= word_addr(frame_q, row_d, col_d);
          be_q    <= be_d;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end
      endcase

      // Abort overrides any transition above; a word accepted on this edge still counts.
      if (abort_cmd) begin
        state_q      <= ST_IDLE;
        req_q        <= 1'b0;
        done_pulse_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.bus_data_fetched = 32'd0;
    if (bus.bus_read_enable && in_win) begin
      case (off)
        OFF_CTRL:  bus.bus_data_fetched = {22'd0, done_q, busy, 6'd0, frame_q, 1'b0};
        OFF_POS:   bus.bus_data_fetched = {8'd0, pos_y_q, 7'd0, pos_x_q};
        OFF_SIZE:  bus.bus_data_fetched = {8'd0, size_h_q, 7'd0, size_w_q};
        default:   bus.bus_data_fetched = {24'd0, color_q};
      endcase
    end
  end

  assign bus.fill_address       = addr_q;
  assign bus.fill_write_data    = {4{color_q}};
  assign bus.fill_byte_enable   = be_q;
  assign bus.fill_write_request = req_q;
  assign bus.fill_busy          = busy;
  assign bus.fill_done          = done_pulse_q;

endmodule

// File: tb/tb_video_rect_fill.sv
// Directed bench for the rectangle-fill engine: programs registers over the
// slave port and logs every accepted master write for comparison.
module tb_video_rect_fill;

  localparam logic [31:0] RB = 32'hFF20_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_rect_fill_if bus ();

  video_rect_fill dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Accept log filled by the monitor; the initial block only reads it.
  int          acc_cnt  = 0;
  int          req_cnt  = 0;
  int          done_cnt = 0;
  int          cyc      = 0;
  logic [31:0] addr_log [64];
  logic [31:0] data_log [64];
  logic [3:0]  be_log   [64];
  int          cyc_log  [64];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fill_write_request) req_cnt <= req_cnt + 1;
    if (bus.fill_done) done_cnt <= done_cnt + 1;
    if (bus.fill_write_request && bus.fill_ready && acc_cnt < 64) begin
      addr_log[acc_cnt] <= bus.fill_address;
      data_log[acc_cnt] <= bus.fill_write_data;
      be_log[acc_cnt]   <= bus.fill_byte_enable;
      cyc_log[acc_cnt]  <= cyc;
      acc_cnt           <= acc_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [3:0] off, input logic [31:0] data);
    bus.bus_address      = RB | {28'd0, off};
    bus.bus_write_data   = data;
    bus.bus_byte_enable  = 4'hF;
    bus.bus_write_enable = 1'b1;
    tick();
    bus.bus_write_enable = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] off, output logic [31:0] data);
    bus.bus_address     = RB | {28'd0, off};
    bus.bus_read_enable = 1'b1;
    #1;
    data = bus.bus_data_fetched;
    bus.bus_read_enable = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && bus.fill_busy; i++) tick();
    check(tag, {31'd0, bus.fill_busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int base, dbase, rbase;
    logic stable_ok, pre_stall;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_be;

    bus.bus_address      = '0;
    bus.bus_write_data   = '0;
    bus.bus_byte_enable  = '0;
    bus.bus_read_enable  = 1'b0;
    bus.bus_write_enable = 1'b0;
    bus.fill_ready       = 1'b0;
    tick(); tick();
    rst = 1'b0;

    check("rst_req",  {31'd0, bus.fill_write_request}, 32'd0);
    check("rst_busy", {31'd0, bus.fill_busy}, 32'd0);
    check("rst_done", {31'd0, bus.fill_done}, 32'd0);
    check("rst_addr", bus.fill_address, 32'd0);
    bus_rd(4'h0, rd); check("rst_ctrl", rd, 32'd0);
    bus_rd(4'h4, rd); check("rst_pos", rd, 32'd0);
    bus.bus_address = 32'hFF20_0010; bus.bus_read_enable = 1'b1; #1;
    check("rd_outside", bus.bus_data_fetched, 32'd0);
    bus.bus_read_enable = 1'b0;

    // 4x1 at origin, frame 0
    bus.fill_ready = 1'b1;
    bus_wr(4'h4, 32'h0000_0000);
    bus_wr(4'h8, 32'h0001_0004);
    bus_wr(4'hC, 32'h0000_00AA);
    bus_rd(4'h8, rd); check("size_rb", rd, 32'h0001_0004);
    base = acc_cnt; dbase = done_cnt;
    bus_wr(4'h0, 32'h1);
    wait_idle("t1_idle");
    check("t1_count", acc_cnt - base, 1);
    check("t1_addr", addr_log[base], 32'hFF00_0000);
    check("t1_be",   {28'd0, be_log[base]}, 32'hF);
    check("t1_data", data_log[base], 32'hAAAA_AAAA);
    check("t1_donepulse", done_cnt - dbase, 1);
    bus_rd(4'h0, rd); check("t1_ctrl", rd, 32'h200);

    // 6x2 at (5,2), frame 1: partial words at both ends, bubble between rows
    bus_wr(4'h4, 32'h0002_0005);
    bus_wr(4'h8, 32'h0002_0006);
    bus_wr(4'hC, 32'h0000_0055);
    base = acc_cnt;
    bus_wr(4'h0, 32'h3);
    wait_idle("t2_idle");
    check("t2_count", acc_cnt - base, 4);
    check("t2_a0", addr_log[base],   32'hFF10_0284);
    check("t2_b0", {28'd0, be_log[base]},   32'hE);
    check("t2_a1", addr_log[base+1], 32'hFF10_0288);
    check("t2_b1", {28'd0, be_log[base+1]}, 32'h7);
    check("t2_a2", addr_log[base+2], 32'hFF10_03C4);
    check("t2_b2", {28'd0, be_log[base+2]}, 32'hE);
    check("t2_a3", addr_log[base+3], 32'hFF10_03C8);
    check("t2_b3", {28'd0, be_log[base+3]}, 32'h7);
    check("t2_data", data_log[base+3], 32'h5555_5555);
    check("t2_gap_in_row", cyc_log[base+1] - cyc_log[base], 1);
    check("t2_bubble", cyc_log[base+2] - cyc_log[base+1], 2);
    bus_rd(4'h0, rd); check("t2_ctrl", rd, 32'h202);

    // Clipped at bottom-right corner: 239*320 + 316 = 0x12BFC
    bus_wr(4'h4, 32'h00EF_013E);
    bus_wr(4'h8, 32'h000A_000A);
    base = acc_cnt;
    bus_wr(4'h0, 32'h1);
    wait_idle("t3_idle");
    check("t3_count", acc_cnt - base, 1);
    check("t3_addr", addr_log[base], 32'hFF01_2BFC);
    check("t3_be", {28'd0, be_log[base]}, 32'hC);
    bus_rd(4'h0, rd); check("t3_ctrl", rd, 32'h200);

    // Empty fill (w=0): DONE two cycles after the start write is presented
    bus_wr(4'h4, 32'h0000_0000);
    bus_wr(4'h8, 32'h0001_0000);
    rbase = req_cnt; dbase = done_cnt;
    bus_wr(4'h0, 32'h1);
    check("t4_done_c1", {31'd0, bus.fill_done}, 32'd0);
    tick();
    check("t4_done_c2", {31'd0, bus.fill_done}, 32'd1);
    tick();
    check("t4_done_c3", {31'd0, bus.fill_done}, 32'd0);
    check("t4_busy", {31'd0, bus.fill_busy}, 32'd0);
    check("t4_noreq", req_cnt - rbase, 0);
    check("t4_pulses", done_cnt - dbase, 1);

    // Empty fill (x=320)
    bus_wr(4'h4, 32'h0000_0140);
    bus_wr(4'h8, 32'h0001_0004);
    rbase = req_cnt; dbase = done_cnt;
    bus_wr(4'h0, 32'h1);
    tick();
    check("t5_done_c2", {31'd0, bus.fill_done}, 32'd1);
    tick();
    check("t5_noreq", req_cnt - rbase, 0);
    bus_rd(4'h0, rd); check("t5_ctrl", rd, 32'h200);

    // 8-word row with ready high 1 cycle in 3: outputs must hold while stalled
    bus_wr(4'h4, 32'h0000_0000);
    bus_wr(4'h8, 32'h0001_0020);
    bus.fill_ready = 1'b0;
    base = acc_cnt;
    stable_ok = 1'b1;
    bus_wr(4'h0, 32'h1);
    for (int i = 0; i < 120 && bus.fill_busy; i++) begin
      bus.fill_ready = ((i % 3) == 2);
      pre_stall = bus.fill_write_request && !bus.fill_ready;
      s_addr = bus.fill_address; s_data = bus.fill_write_data; s_be = bus.fill_byte_enable;
      tick();
      if (pre_stall && (!bus.fill_write_request || bus.fill_address !== s_addr ||
                        bus.fill_write_data !== s_data || bus.fill_byte_enable !== s_be))
        stable_ok = 1'b0;
    end
    check("t6_idle", {31'd0, bus.fill_busy}, 32'd0);
    check("t6_stable", {31'd0, stable_ok}, 32'd1);
    check("t6_count", acc_cnt - base, 8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t6_addr%0d", k), addr_log[base+k], 32'hFF00_0000 + 32'(4*k));
    end
    check("t6_be_last", {28'd0, be_log[base+7]}, 32'hF);

    // Abort after the third accept of a 2x2-word fill
    bus_wr(4'h8, 32'h0002_0008);
    bus.fill_ready = 1'b1;
    base = acc_cnt; dbase = done_cnt;
    bus_wr(4'h0, 32'h1);
    for (int i = 0; i < 50 && (acc_cnt - base) < 3; i++) tick();
    check("t7_reach3", acc_cnt - base, 3);
    bus.fill_ready = 1'b0;
    bus_wr(4'h0, 32'h4);
    check("t7_busy", {31'd0, bus.fill_busy}, 32'd0);
    check("t7_req", {31'd0, bus.fill_write_request}, 32'd0);
    bus.fill_ready = 1'b1;
    tick(); tick(); tick();
    check("t7_count", acc_cnt - base, 3);
    check("t7_nopulse", done_cnt - dbase, 0);
    bus_rd(4'h0, rd); check("t7_ctrl", rd, 32'h000);

    // Reset in the middle of a stalled fill; POS write while busy is ignored
    bus.fill_ready = 1'b0;
    bus_wr(4'h4, 32'h0000_0010);
    bus_wr(4'h0, 32'h1);
    tick(); tick();
    check("t8_busy", {31'd0, bus.fill_busy}, 32'd1);
    check("t8_req", {31'd0, bus.fill_write_request}, 32'd1);
    bus_wr(4'h4, 32'h0005_0007);
    bus_rd(4'h4, rd); check("t8_pos_locked", rd, 32'h0000_0010);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t8_req_rst", {31'd0, bus.fill_write_request}, 32'd0);
    check("t8_busy_rst", {31'd0, bus.fill_busy}, 32'd0);
    bus_rd(4'h0, rd); check("t8_ctrl_rst", rd, 32'h000);
    rbase = req_cnt;
    bus.fill_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t8_noreq", req_cnt - rbase, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
